// File: rtl/p4_router_queue_state_table.sv
// Per-queue state store for the router packet buffer: word/byte occupancy, head/tail word pointers,
// per-queue linked page lists, empty/threshold flags and drained-page return.
module p4_router_queue_state_table #(
   parameter int NUM_QUEUES      = 32,
   parameter int NUM_PAGES       = 1024,
   parameter int WORDS_PER_PAGE  = 32,
   parameter int BYTES_PER_WORD  = 64,
   parameter int PAGES_PER_QUEUE = 64,
   localparam int QW    = $clog2(NUM_QUEUES),
   localparam int PW    = $clog2(NUM_PAGES),
   localparam int WW    = $clog2(WORDS_PER_PAGE),
   localparam int BW    = $clog2(BYTES_PER_WORD + 1),
   localparam int OCC_W = $clog2(NUM_PAGES * WORDS_PER_PAGE * BYTES_PER_WORD + 1)
) (
   input  logic                  clk,
   input  logic                  sreset,
   input  logic                  enq_valid,
   input  logic [QW-1:0]         enq_queue,
   input  logic [BW-1:0]         enq_bytes,
   input  logic                  enq_page_valid,
   input  logic [PW-1:0]         enq_page_ptr,
   output logic [PW+WW-1:0]      enq_addr,
   output logic                  enq_rsp_valid,
   output logic [1:0]            enq_err,
   input  logic                  deq_valid,
   output logic                  deq_ready,
   input  logic [QW-1:0]         deq_queue,
   input  logic [BW-1:0]         deq_bytes,
   output logic [PW+WW-1:0]      deq_addr,
   output logic                  deq_rsp_valid,
   output logic                  deq_err,
   output logic                  free_valid,
   output logic [PW-1:0]         free_page_ptr,
   input  logic                  cfg_we,
   input  logic [QW-1:0]         cfg_queue,
   input  logic [OCC_W-1:0]      cfg_thresh,
   input  logic                  occ_rd_valid,
   input  logic [QW-1:0]         occ_rd_queue,
   output logic [OCC_W-1:0]      occ_rd_data,
   output logic                  occ_rsp_valid,
   output logic [NUM_QUEUES-1:0] queue_empty,
   output logic [NUM_QUEUES-1:0] queue_above_thr
);

   localparam int FW  = $clog2(PAGES_PER_QUEUE);
   localparam int FCW = FW + 1;
   localparam int CW  = $clog2(NUM_PAGES * WORDS_PER_PAGE + 1);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] ADVANCE = 1'b1;

   logic [CW-1:0]    word_cnt     [NUM_QUEUES];
   logic [CW-1:0]    word_cnt_nx  [NUM_QUEUES];
   logic [OCC_W-1:0] occ_bytes    [NUM_QUEUES];
   logic [OCC_W-1:0] occ_bytes_nx [NUM_QUEUES];
   logic [WW-1:0]    head_word    [NUM_QUEUES];
   logic [WW-1:0]    head_word_nx [NUM_QUEUES];
   logic [PW-1:0]    head_page    [NUM_QUEUES];
   logic [PW-1:0]    head_page_nx [NUM_QUEUES];
   logic [WW-1:0]    tail_word    [NUM_QUEUES];
   logic [WW-1:0]    tail_word_nx [NUM_QUEUES];
   logic [PW-1:0]    tail_page    [NUM_QUEUES];
   logic [PW-1:0]    tail_page_nx [NUM_QUEUES];
   logic [FW-1:0]    fifo_rd      [NUM_QUEUES];
   logic [FW-1:0]    fifo_rd_nx   [NUM_QUEUES];
   logic [FW-1:0]    fifo_wr      [NUM_QUEUES];
   logic [FW-1:0]    fifo_wr_nx   [NUM_QUEUES];
   logic [FCW-1:0]   fifo_cnt     [NUM_QUEUES];
   logic [FCW-1:0]   fifo_cnt_nx  [NUM_QUEUES];
   logic [OCC_W-1:0] thresh       [NUM_QUEUES];

   logic [PW-1:0]    fifo_ram     [NUM_QUEUES*PAGES_PER_QUEUE];
   logic [PW-1:0]    fifo_rd_data;
   logic [QW-1:0]    adv_queue;
   logic [0:0]       state;

   logic             enq_need_page;
   logic             enq_ok;
   logic             enq_push;
   logic [1:0]       enq_err_nx;
   logic [PW-1:0]    enq_page_sel;
   logic             deq_accept;
   logic             deq_ok;
   logic             deq_free;
   logic             deq_pop;

   // An enqueue carrying a page to the same queue wins the cycle, as does the head-page reload.
   assign deq_ready = (state == RUN) &&
                      !(enq_valid && enq_page_valid && (enq_queue == deq_queue));

   always_comb begin
      word_cnt_nx   = word_cnt;
      occ_bytes_nx  = occ_bytes;
      head_word_nx  = head_word;
      head_page_nx  = head_page;
      tail_word_nx  = tail_word;
      tail_page_nx  = tail_page;
      fifo_rd_nx    = fifo_rd;
      fifo_wr_nx    = fifo_wr;
      fifo_cnt_nx   = fifo_cnt;
      enq_err_nx    = '0;
      enq_ok        = 1'b0;
      enq_push      = 1'b0;
      enq_need_page = (tail_word[enq_queue] == '0);
      enq_page_sel  = enq_need_page ? enq_page_ptr : tail_page[enq_queue];
      deq_accept    = deq_valid && deq_ready;
      deq_ok        = deq_accept && (word_cnt[deq_queue] != '0);
      deq_free      = deq_ok && (head_word[deq_queue] == WW'(WORDS_PER_PAGE - 1));
      deq_pop       = deq_free && (fifo_cnt[deq_queue] != '0);

      if (state == ADVANCE)
         head_page_nx[adv_queue] = fifo_rd_data;

      if (enq_valid) begin
         if (enq_need_page && !enq_page_valid)
            enq_err_nx[0] = 1'b1;
         else if (enq_need_page && (word_cnt[enq_queue] != '0) &&
                  (fifo_cnt[enq_queue] == FCW'(PAGES_PER_QUEUE)))
            enq_err_nx[1] = 1'b1;
         else
            enq_ok = 1'b1;
      end

      // An empty queue takes its new page straight into head and tail; otherwise it is chained.
      if (enq_ok) begin
         enq_push = enq_need_page && (word_cnt[enq_queue] != '0);
         if (enq_need_page && (word_cnt[enq_queue] == '0))
            head_page_nx[enq_queue] = enq_page_ptr;
         if (enq_push) begin
            fifo_wr_nx[enq_queue]  = fifo_wr[enq_queue] + 1'b1;
            fifo_cnt_nx[enq_queue] = fifo_cnt[enq_queue] + 1'b1;
         end
         tail_page_nx[enq_queue] = enq_page_sel;
         tail_word_nx[enq_queue] = tail_word[enq_queue] + 1'b1;
         word_cnt_nx[enq_queue]  = word_cnt[enq_queue] + 1'b1;
         occ_bytes_nx[enq_queue] = occ_bytes[enq_queue] + OCC_W'(enq_bytes);
      end

      if (deq_ok) begin
         head_word_nx[deq_queue] = head_word[deq_queue] + 1'b1;
         word_cnt_nx[deq_queue]  = word_cnt_nx[deq_queue] - 1'b1;
         occ_bytes_nx[deq_queue] = (occ_bytes_nx[deq_queue] >= OCC_W'(deq_bytes)) ?
                                   occ_bytes_nx[deq_queue] - OCC_W'(deq_bytes) : '0;
         if (deq_pop) begin
            fifo_rd_nx[deq_queue]  = fifo_rd[deq_queue] + 1'b1;
            fifo_cnt_nx[deq_queue] = fifo_cnt_nx[deq_queue] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         for (int i = 0; i < NUM_QUEUES; i++) begin
            word_cnt[i]  <= '0;
            occ_bytes[i] <= '0;
            head_word[i] <= '0;
            head_page[i] <= '0;
            tail_word[i] <= '0;
            tail_page[i] <= '0;
            fifo_rd[i]   <= '0;
            fifo_wr[i]   <= '0;
            fifo_cnt[i]  <= '0;
            thresh[i]    <= '1;
         end
         state           <= RUN;
         adv_queue       <= '0;
         enq_addr        <= '0;
         enq_rsp_valid   <= 1'b0;
         enq_err         <= '0;
         deq_addr        <= '0;
         deq_rsp_valid   <= 1'b0;
         deq_err         <= 1'b0;
         free_valid      <= 1'b0;
         free_page_ptr   <= '0;
         occ_rd_data     <= '0;
         occ_rsp_valid   <= 1'b0;
         queue_empty     <= '1;
         queue_above_thr <= '0;
      end else begin
         word_cnt  <= word_cnt_nx;
         occ_bytes <= occ_bytes_nx;
         head_word <= head_word_nx;
         head_page <= head_page_nx;
         tail_word <= tail_word_nx;
         tail_page <= tail_page_nx;
         fifo_rd   <= fifo_rd_nx;
         fifo_wr   <= fifo_wr_nx;
         fifo_cnt  <= fifo_cnt_nx;
         if (cfg_we)
            thresh[cfg_queue] <= cfg_thresh;
         for (int i = 0; i < NUM_QUEUES; i++) begin
            queue_empty[i]     <= (word_cnt_nx[i] == '0);
            queue_above_thr[i] <= (occ_bytes_nx[i] >= thresh[i]);
         end
         state <= deq_pop ? ADVANCE : RUN;
         if (deq_pop)
            adv_queue <= deq_queue;
         enq_rsp_valid <= enq_valid;
         enq_err       <= enq_err_nx;
         if (enq_valid)
            enq_addr <= {enq_page_sel, tail_word[enq_queue]};
         deq_rsp_valid <= deq_accept;
         deq_err       <= deq_accept && !deq_ok;
         if (deq_accept)
            deq_addr <= {head_page[deq_queue], head_word[deq_queue]};
         free_valid <= deq_free;
         if (deq_free)
            free_page_ptr <= head_page[deq_queue];
         occ_rsp_valid <= occ_rd_valid;
         occ_rd_data   <= occ_bytes[occ_rd_queue];
      end
   end

   // Page-list RAM; the popped entry is read here and lands in head_page during ADVANCE.
   always_ff @(posedge clk) begin
      if (enq_push && !sreset)
         fifo_ram[{enq_queue, fifo_wr[enq_queue]}] <= enq_page_ptr;
      fifo_rd_data <= fifo_ram[{deq_queue, fifo_rd[deq_queue]}];
   end

endmodule

// File: tb/tb_p4_router_queue_state_table.sv
// Bench for p4_router_queue_state_table: directed scenarios and random traffic, each cycle compared
// against a reference model that keeps every queue as a list of buffer addresses.
module tb_p4_router_queue_state_table;

   localparam int NQ    = 32;
   localparam int NP    = 1024;
   localparam int WPP   = 32;
   localparam int PPQ   = 64;
   localparam int QW    = 5;
   localparam int PW    = 10;
   localparam int WW    = 5;
   localparam int BW    = 7;
   localparam int OCC_W = 22;

   logic             clk;
   logic             sreset;
   logic             enq_valid;
   logic [QW-1:0]    enq_queue;
   logic [BW-1:0]    enq_bytes;
   logic             enq_page_valid;
   logic [PW-1:0]    enq_page_ptr;
   logic [PW+WW-1:0] enq_addr;
   logic             enq_rsp_valid;
   logic [1:0]       enq_err;
   logic             deq_valid;
   logic             deq_ready;
   logic [QW-1:0]    deq_queue;
   logic [BW-1:0]    deq_bytes;
   logic [PW+WW-1:0] deq_addr;
   logic             deq_rsp_valid;
   logic             deq_err;
   logic             free_valid;
   logic [PW-1:0]    free_page_ptr;
   logic             cfg_we;
   logic [QW-1:0]    cfg_queue;
   logic [OCC_W-1:0] cfg_thresh;
   logic             occ_rd_valid;
   logic [QW-1:0]    occ_rd_queue;
   logic [OCC_W-1:0] occ_rd_data;
   logic             occ_rsp_valid;
   logic [NQ-1:0]    queue_empty;
   logic [NQ-1:0]    queue_above_thr;

   p4_router_queue_state_table dut (
      .clk(clk), .sreset(sreset),
      .enq_valid(enq_valid), .enq_queue(enq_queue), .enq_bytes(enq_bytes),
      .enq_page_valid(enq_page_valid), .enq_page_ptr(enq_page_ptr),
      .enq_addr(enq_addr), .enq_rsp_valid(enq_rsp_valid), .enq_err(enq_err),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_queue(deq_queue), .deq_bytes(deq_bytes),
      .deq_addr(deq_addr), .deq_rsp_valid(deq_rsp_valid), .deq_err(deq_err),
      .free_valid(free_valid), .free_page_ptr(free_page_ptr),
      .cfg_we(cfg_we), .cfg_queue(cfg_queue), .cfg_thresh(cfg_thresh),
      .occ_rd_valid(occ_rd_valid), .occ_rd_queue(occ_rd_queue),
      .occ_rd_data(occ_rd_data), .occ_rsp_valid(occ_rsp_valid),
      .queue_empty(queue_empty), .queue_above_thr(queue_above_thr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Reference model: each queue is the ordered list of {page,word} addresses it holds.
   int unsigned mAddr     [NQ][$];
   longint      mOcc      [NQ];
   longint      mThr      [NQ];
   int          mTailWord [NQ];
   int          mTailPage [NQ];
   int          mListed   [NQ];
   bit          mAdvance;
   int          pageCtr = 100;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      for (int q = 0; q < NQ; q++) begin
         mAddr[q].delete();
         mOcc[q]      = 0;
         mThr[q]      = (64'd1 << OCC_W) - 1;
         mTailWord[q] = 0;
         mTailPage[q] = 0;
         mListed[q]   = 0;
      end
      mAdvance = 0;
   endtask

   // Reset is held with live requests on the inputs; nothing may answer them.
   task automatic doReset();
      sreset = 1'b1;
      enq_valid = 1'b1; enq_queue = '0; enq_bytes = 7'd64; enq_page_valid = 1'b1; enq_page_ptr = 10'd1;
      deq_valid = 1'b1; deq_queue = '0; deq_bytes = 7'd64;
      cfg_we = 1'b0; cfg_queue = '0; cfg_thresh = '0;
      occ_rd_valid = 1'b1; occ_rd_queue = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_enq_rsp_valid", enq_rsp_valid, 0);
      checkOutput("rst_enq_err", enq_err, 0);
      checkOutput("rst_enq_addr", enq_addr, 0);
      checkOutput("rst_deq_rsp_valid", deq_rsp_valid, 0);
      checkOutput("rst_deq_err", deq_err, 0);
      checkOutput("rst_deq_addr", deq_addr, 0);
      checkOutput("rst_free_valid", free_valid, 0);
      checkOutput("rst_occ_rsp_valid", occ_rsp_valid, 0);
      checkOutput("rst_occ_rd_data", occ_rd_data, 0);
      checkOutput("rst_queue_empty", queue_empty, {NQ{1'b1}});
      checkOutput("rst_queue_above_thr", queue_above_thr, 0);
      sreset = 1'b0;
      enq_valid = 1'b0; deq_valid = 1'b0; occ_rd_valid = 1'b0; enq_page_valid = 1'b0;
      resetModel();
      #1;
      checkOutput("rst_deq_ready", deq_ready, 1);
   endtask

   task automatic applyStimulus(input bit ev, input int eq, input int eb, input bit epv, input int ep,
                                input bit dv, input int dq, input int db,
                                input bit cw, input int cq, input longint ct,
                                input bit ov, input int oq);
      bit          expReady, deqAcc, deqOk, enqOk, expFree;
      int          expEnqErr, expFreePage, enqPreSize, page;
      int unsigned expEnqAddr, expDeqAddr;
      longint      expOcc;
      logic [NQ-1:0] expEmpty, expAbove;
      enq_valid = ev; enq_queue = eq[QW-1:0]; enq_bytes = eb[BW-1:0];
      enq_page_valid = epv; enq_page_ptr = ep[PW-1:0];
      deq_valid = dv; deq_queue = dq[QW-1:0]; deq_bytes = db[BW-1:0];
      cfg_we = cw; cfg_queue = cq[QW-1:0]; cfg_thresh = ct[OCC_W-1:0];
      occ_rd_valid = ov; occ_rd_queue = oq[QW-1:0];
      #1;
      expReady = !mAdvance && !(ev && epv && (eq == dq));
      checkOutput("deq_ready", deq_ready, expReady);
      deqAcc = dv && expReady;
      deqOk  = deqAcc && (mAddr[dq].size() != 0);
      enqPreSize = mAddr[eq].size();
      expEnqErr = 0; enqOk = 0; expEnqAddr = 0; expDeqAddr = 0; expFree = 0; expFreePage = 0;
      if (ev) begin
         if (mTailWord[eq] == 0 && !epv) expEnqErr = 1;
         else if (mTailWord[eq] == 0 && enqPreSize != 0 && mListed[eq] == PPQ) expEnqErr = 2;
         else enqOk = 1;
      end
      expOcc = mOcc[oq];
      mAdvance = 0;
      if (deqOk) begin
         expDeqAddr = mAddr[dq].pop_front();
         if (expDeqAddr % WPP == WPP - 1) begin
            expFree = 1;
            expFreePage = expDeqAddr / WPP;
            if (mListed[dq] > 0) begin
               mListed[dq]--;
               mAdvance = 1;
            end
         end
      end
      if (enqOk) begin
         page = (mTailWord[eq] == 0) ? ep : mTailPage[eq];
         if (mTailWord[eq] == 0 && enqPreSize != 0) mListed[eq]++;
         expEnqAddr = page * WPP + mTailWord[eq];
         mAddr[eq].push_back(expEnqAddr);
         mTailPage[eq] = page;
         mTailWord[eq] = (mTailWord[eq] + 1) % WPP;
         mOcc[eq] += eb;
      end
      if (deqOk) mOcc[dq] = (mOcc[dq] >= db) ? mOcc[dq] - db : 0;
      for (int q = 0; q < NQ; q++) begin
         expEmpty[q] = (mAddr[q].size() == 0);
         expAbove[q] = (mOcc[q] >= mThr[q]);
      end
      if (cw) mThr[cq] = ct;
      @(posedge clk);
      #1;
      checkOutput("enq_rsp_valid", enq_rsp_valid, ev);
      checkOutput("enq_err", enq_err, expEnqErr);
      if (enqOk) checkOutput("enq_addr", enq_addr, expEnqAddr);
      checkOutput("deq_rsp_valid", deq_rsp_valid, deqAcc);
      checkOutput("deq_err", deq_err, deqAcc && !deqOk);
      if (deqOk) checkOutput("deq_addr", deq_addr, expDeqAddr);
      checkOutput("free_valid", free_valid, expFree);
      if (expFree) checkOutput("free_page_ptr", free_page_ptr, expFreePage);
      checkOutput("occ_rsp_valid", occ_rsp_valid, ov);
      if (ov) checkOutput("occ_rd_data", occ_rd_data, expOcc);
      checkOutput("queue_empty", queue_empty, expEmpty);
      checkOutput("queue_above_thr", queue_above_thr, expAbove);
   endtask

   task automatic enqWord(input int q, input int b, input bit pv, input int p);
      applyStimulus(1, q, b, pv, p, 0, 0, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic deqWord(input int q, input int b);
      applyStimulus(0, 0, 1, 0, 0, 1, q, b, 0, 0, 0, 0, 0);
   endtask

   task automatic readOcc(input int q);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, q);
   endtask

   initial begin
      sreset = 1'b1;
      resetModel();
      doReset();

      // q3: four words on page 5, then drained again
      enqWord(3, 64, 1, 5);
      checkOutput("q3_first_addr", enq_addr, 5 * WPP + 0);
      for (int i = 1; i < 4; i++) enqWord(3, 64, 0, 0);
      checkOutput("q3_last_addr", enq_addr, 5 * WPP + 3);
      readOcc(3);
      checkOutput("q3_occ_256", occ_rd_data, 256);
      checkOutput("q3_not_empty", queue_empty[3], 0);
      for (int i = 0; i < 4; i++) deqWord(3, 64);
      checkOutput("q3_drained_empty", queue_empty[3], 1);
      readOcc(3);
      checkOutput("q3_occ_0", occ_rd_data, 0);

      // q1: 33 words across pages 7 and 9, drained through the page boundary
      enqWord(1, 64, 1, 7);
      for (int i = 1; i < 32; i++) enqWord(1, 64, 0, 0);
      enqWord(1, 64, 1, 9);
      checkOutput("q1_word32_addr", enq_addr, 9 * WPP + 0);
      for (int i = 0; i < 32; i++) deqWord(1, 64);
      checkOutput("q1_free_valid", free_valid, 1);
      checkOutput("q1_free_page", free_page_ptr, 7);
      checkOutput("q1_advance_ready", deq_ready, 0);
      deqWord(1, 64);
      deqWord(1, 64);
      checkOutput("q1_next_addr", deq_addr, 9 * WPP + 0);
      checkOutput("q1_empty", queue_empty[1], 1);

      // errors: dequeue from empty queue, enqueue at word 0 without a page
      deqWord(0, 64);
      checkOutput("q0_deq_err", deq_err, 1);
      enqWord(2, 64, 0, 0);
      checkOutput("q2_enq_err", enq_err, 1);
      checkOutput("q2_still_empty", queue_empty[2], 1);

      // threshold on q4
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 1, 4, 128, 0, 0);
      enqWord(4, 64, 1, 20);
      checkOutput("q4_below_thr", queue_above_thr[4], 0);
      enqWord(4, 64, 0, 0);
      checkOutput("q4_above_thr", queue_above_thr[4], 1);
      deqWord(4, 64);
      checkOutput("q4_below_again", queue_above_thr[4], 0);

      // q6: simultaneous enqueue/dequeue keeps the count, then drain with saturation
      enqWord(6, 64, 1, 30);
      for (int i = 1; i < 5; i++) enqWord(6, 64, 0, 0);
      applyStimulus(1, 6, 10, 0, 0, 1, 6, 40, 0, 0, 0, 0, 0);
      readOcc(6);
      checkOutput("q6_occ_net", occ_rd_data, 290);
      for (int i = 0; i < 4; i++) deqWord(6, 64);
      checkOutput("q6_cnt_one_left", queue_empty[6], 0);
      deqWord(6, 64);
      checkOutput("q6_cnt_zero", queue_empty[6], 1);
      readOcc(6);
      checkOutput("q6_occ_saturated", occ_rd_data, 0);

      // q7: page-list overflow on the (PAGES_PER_QUEUE+1)th chained page
      for (int i = 0; i <= PPQ * WPP + WPP; i++)
         enqWord(7, 1, (i % WPP) == 0, 200 + i / WPP);
      checkOutput("q7_overflow_err", enq_err, 2);

      doReset();

      // randomized traffic on a handful of queues
      for (int n = 0; n < 3000; n++) begin
         int rq, rdq, rpg, rb, rdb, rcq;
         bit rev, rpv, rdv, rcw, rov;
         longint rct;
         if (n == 1500) doReset();
         rq  = $urandom_range(0, 3);
         rdq = $urandom_range(0, 3);
         rev = ($urandom_range(0, 9) < 6);
         rdv = ($urandom_range(0, 9) < 5);
         if (mTailWord[rq] == 0) rpv = ($urandom_range(0, 9) != 0);
         else rpv = ($urandom_range(0, 9) == 0);
         rpg = pageCtr;
         if (rev && rpv) pageCtr = (pageCtr + 1) % NP;
         rb  = $urandom_range(1, 64);
         rdb = $urandom_range(1, 64);
         rcw = ($urandom_range(0, 19) == 0);
         rcq = $urandom_range(0, 3);
         rct = $urandom_range(0, 2000);
         rov = ($urandom_range(0, 9) < 3);
         applyStimulus(rev, rq, rb, rpv, rpg, rdv, rdq, rdb, rcw, rcq, rct, rov, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
